trivium_keystream_core: RTL
===========================

Name: trivium_keystream_core

Overview:
- Trivium keystream generator feeding the stream processor's XOR/output stage.
- Expands an 8-bit seed into an 80-bit key and an 80-bit IV, then runs the standard 288-bit Trivium initialisation and warm-up.
- Emits packed keystream bytes over a valid/ready handshake, one new byte per 8 cipher clocks.
- The consumer XORs each byte with ui_in data, so identical seeds must yield identical byte sequences (encrypt/decrypt symmetry).

Parameters:
- WARMUP_CYCLES, 1152: number of initialisation clocks discarded before the first output bit (4*288). Must be >= 1; values < 1152 are for simulation only.
- CNT_W, 11: width of the warm-up counter; must satisfy 2^CNT_W > WARMUP_CYCLES.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- seed_in  in  8  seed value, sampled when seed_load=1
- seed_load  in  1  single-cycle pulse: load seed and start initialisation
- restart  in  1  single-cycle pulse: clear state, return to IDLE (consumer drives it on uio_in==8'hFF)
- ks_ready  in  1  consumer accepts ks_byte this cycle
- ks_byte  out  8  keystream byte; first generated bit in bit 0, last in bit 7
- ks_valid  out  1  ks_byte holds a complete, unconsumed byte
- busy  out  1  high in WARMUP

Behaviour:
- Reset (async, rst_n=0):
  - state register s[1..288]=0, FSM=IDLE, bit counter=0, warm-up counter=0.
  - ks_byte=8'h00, ks_valid=0, busy=0.
- Seed expansion:
  - key[79:0] = {10{seed_in}}.
  - iv[79:0] = {10{seed_in ^ 8'h5A}}.
- Load (clock edge with seed_load=1):
  - s[1..80]=key[79:0] with key bit 79 into s1; s[81..93]=0.
  - s[94..173]=iv[79:0] with iv bit 79 into s94; s[174..285]=0; s[286..288]=1.
  - Warm-up counter=0; FSM goes to WARMUP.
- Round function (standard Trivium, one bit per clock):
  - t1=s66^s93; t2=s162^s177; t3=s243^s288; z=t1^t2^t3.
  - t1'=t1^(s91&s92)^s171; t2'=t2^(s175&s176)^s264; t3'=t3^(s286&s287)^s69.
  - Shift: s1..93 <= {t3',s1..92}; s94..177 <= {t1',s94..176}; s178..288 <= {t2',s178..287}.
- FSM:
  - IDLE: cipher frozen; ks_valid=0. Goes to WARMUP on seed_load.
  - WARMUP: cipher steps every clock; z is discarded; busy=1. After exactly WARMUP_CYCLES steps, goes to RUN.
  - RUN: cipher steps every clock; z is shifted into a byte accumulator at index bit_cnt. On the 8th bit, the accumulator is copied to ks_byte, ks_valid goes to 1, bit_cnt goes to 0, and FSM goes to HOLD.
  - HOLD: cipher frozen; ks_byte stable. On ks_ready=1, ks_valid goes to 0 the next clock and FSM returns to RUN.
- Latency:
  - First ks_valid rises WARMUP_CYCLES+8 clocks after the seed_load edge.
  - With ks_ready tied high, each later byte follows 9 clocks after the previous one (8 RUN clocks + 1 HOLD clock).
- ks_ready while ks_valid=0 is ignored.
- seed_load in any state, including mid-WARMUP/RUN/HOLD:
  - Aborts the current operation, discards the pending byte (ks_valid=0 next clock), and reloads the state.
- restart: goes to IDLE next clock; s cleared to 0; ks_valid=0; ks_byte=8'h00; counters cleared.
- seed_load and restart in the same cycle: seed_load wins, and the block behaves as a fresh load.
- No output is produced without a prior load; an all-zero state never reaches RUN.

Optional Feature:
- Macro: TRIVIUM_PREFETCH_EN.
- Defined:
  - Adds a one-entry byte skid buffer, so the cipher keeps generating while ks_valid is high.
  - Accumulation stalls only when the output register and the skid buffer are both full.
  - With ks_ready tied high, bytes arrive every 8 clocks after the first.
  - The byte order is identical to the non-prefetch build.
  - seed_load and restart also flush the skid buffer.
- Undefined: HOLD-stall behaviour exactly as described above.

Test Plan:
- Reset then idle: rst_n low 50 ns, release, no seed_load for 100 clocks -> ks_valid=0, ks_byte=8'h00, busy=0 throughout.
- Warm-up timing (WARMUP_CYCLES=16, ks_ready=1): seed_load pulse with seed_in=8'h23 -> busy high for exactly 16 clocks, first ks_valid at clock 24, then ks_valid pulses every 9 clocks (every 8 with TRIVIUM_PREFETCH_EN).
- Golden bytes (WARMUP_CYCLES=1152, seed 8'h23 and 8'h00) -> first 16 ks_bytes match the bit-accurate software Trivium model with the key/IV expansion defined above.
- Determinism/backpressure: seed 8'h23, hold ks_ready low 50 clocks between accepts, then restart, reload 8'h23 with ks_ready=1 -> both byte sequences identical; ks_byte stable while ks_valid=1 and ks_ready=0.
- Mid-operation events: seed_load during RUN with bit_cnt=5 -> ks_valid=0 next clock, sequence restarts from byte 0; seed_load+restart in the same cycle -> behaves as a load; rst_n asserted during HOLD -> all outputs 0 asynchronously.
- Restart: restart pulse in HOLD -> IDLE, ks_valid=0 next clock; no further bytes until the next seed_load.

Source files
------------

// File: rtl/trivium_keystream_core.sv
// rtl/trivium_keystream_core.sv - Trivium keystream byte generator; TRIVIUM_PREFETCH_EN adds a one-byte skid buffer
`timescale 1ns/1ps
module trivium_keystream_core #(
  parameter int WARMUP_CYCLES = 1152,
  parameter int CNT_W         = 11
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] seed_in,
  input  logic       seed_load,
  input  logic       restart,
  input  logic       ks_ready,
  output logic [7:0] ks_byte,
  output logic       ks_valid,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, WARMUP, RUN, HOLD} state_t;

  state_t       state, state_nx;
  logic [287:0] s;          // s[i-1] holds Trivium bit s(i)
  logic [287:0] s_step, s_seed;
  logic [CNT_W-1:0] wcnt;
  logic [2:0]   bit_cnt;
  logic [6:0]   acc;
  logic [79:0]  key, iv;
  logic         t1, t2, t3, z, n1, n2, n3;
  logic         step, byte_done;
  logic [7:0]   new_byte;
`ifdef TRIVIUM_PREFETCH_EN
  logic [7:0]   skid_byte;
  logic         skid_valid;
`endif

  always_comb begin
    t1 = s[65] ^ s[92];
    t2 = s[161] ^ s[176];
    t3 = s[242] ^ s[287];
    z  = t1 ^ t2 ^ t3;
    n1 = t1 ^ (s[90] & s[91]) ^ s[170];
    n2 = t2 ^ (s[174] & s[175]) ^ s[263];
    n3 = t3 ^ (s[285] & s[286]) ^ s[68];
    s_step = {s[286:177], n2, s[175:93], n1, s[91:0], n3};
  end

  // Key/IV bit 79 lands in s1 / s94, so both fields load bit-reversed.
  always_comb begin
    key    = {10{seed_in}};
    iv     = {10{seed_in ^ 8'h5A}};
    s_seed = '0;
    for (int j = 0; j < 80; j++) begin
      s_seed[j]      = key[79-j];
      s_seed[93+j]   = iv[79-j];
    end
    s_seed[287:285] = 3'b111;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    step     = 1'b0;
    case (state)
      WARMUP: begin
        step = 1'b1;
        if (wcnt == CNT_W'(WARMUP_CYCLES - 1)) state_nx = RUN;
      end
      RUN: begin
`ifdef TRIVIUM_PREFETCH_EN
        step = !(ks_valid && skid_valid);
`else
        step = 1'b1;
        if (bit_cnt == 3'd7) state_nx = HOLD;
`endif
      end
      HOLD: if (ks_ready) state_nx = RUN;
      default: ;
    endcase
    if (restart)   state_nx = IDLE;
    if (seed_load) state_nx = WARMUP;
  end

  assign byte_done = step && (state == RUN) && (bit_cnt == 3'd7);
  assign new_byte  = {z, acc};
  assign busy      = (state == WARMUP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s <= '0; wcnt <= '0; bit_cnt <= '0; acc <= '0;
      ks_byte <= 8'h00; ks_valid <= 1'b0;
`ifdef TRIVIUM_PREFETCH_EN
      skid_byte <= 8'h00; skid_valid <= 1'b0;
`endif
    end else if (seed_load || restart) begin
      s <= seed_load ? s_seed : '0;
      wcnt <= '0; bit_cnt <= '0; acc <= '0;
      ks_byte <= 8'h00; ks_valid <= 1'b0;
`ifdef TRIVIUM_PREFETCH_EN
      skid_byte <= 8'h00; skid_valid <= 1'b0;
`endif
    end else begin
      if (step) s <= s_step;
      if (state == WARMUP) wcnt <= wcnt + 1'b1;
      // First generated bit shifts down to acc[0] by the time the byte completes.
      if (step && state == RUN) begin
        bit_cnt <= bit_cnt + 1'b1;
        acc     <= {z, acc[6:1]};
      end
`ifdef TRIVIUM_PREFETCH_EN
      if (ks_valid && ks_ready) begin
        if (skid_valid) begin
          ks_byte    <= skid_byte;
          skid_valid <= byte_done;
          if (byte_done) skid_byte <= new_byte;
        end else begin
          ks_valid <= byte_done;
          if (byte_done) ks_byte <= new_byte;
        end
      end else if (byte_done) begin
        if (!ks_valid) begin
          ks_byte  <= new_byte;
          ks_valid <= 1'b1;
        end else begin
          skid_byte  <= new_byte;
          skid_valid <= 1'b1;
        end
      end
`else
      if (byte_done) begin
        ks_byte  <= new_byte;
        ks_valid <= 1'b1;
      end else if (state == HOLD && ks_ready) begin
        ks_valid <= 1'b0;
      end
`endif
    end
  end
endmodule
